// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the multi-cycle multiply/divide unit.
//   MULDIV_WIDTH : default operand and HI/LO width
//   OP_*         : op encodings driven by the decoder
//   ST_*         : sequencer state encodings
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational iteration of the multiply/divide engine.
//   is_div   in  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_in   in  : 2*WIDTH accumulator
//                  multiply: {partial product high, remaining multiplier bits}
//                  divide:   {partial remainder, remaining dividend / quotient bits}
//   operand  in  : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   acc_out  out : accumulator after this step
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        // multiply: add multiplicand when the current LSB is set, then shift right
        // keeping the carry as the new top bit
        mul_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
                + ({(WIDTH+1){acc_in[0]}} & {1'b0, operand});

        // divide: bring down the next dividend bit into a WIDTH+1 bit remainder
        shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, operand};

        acc_out = {mul_sum, acc_in[WIDTH-1:1]};
        if (is_div) begin
            // borrow means the trial subtract failed: restore, quotient bit 0.
            // The kept remainder is always below the divisor, so WIDTH bits suffice.
            if (diff[WIDTH+1]) begin
                acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//   clk    in  : system clock
//   reset  in  : synchronous active-low reset
//   start  in  : request a new operation (accepted only when idle)
//   op     in  : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   srca   in  : multiplicand / dividend
//   srcb   in  : multiplier / divisor
//   rd_req in  : datapath executing MFHI/MFLO
//   mthi   in  : write wdata to HI (idle only)
//   mtlo   in  : write wdata to LO (idle only)
//   wdata  in  : MTHI/MTLO data
//   hi     out : HI register
//   lo     out : LO register
//   busy   out : operation in flight
//   done   out : one-cycle pulse after HI/LO receive a result
//   stall  out : datapath must hold the current instruction
//
// state    | meaning
// ST_IDLE  | waiting; start and MTHI/MTLO accepted
// ST_RUN   | WIDTH iteration cycles, one bit per cycle
// ST_FIXUP | apply signs, write HI/LO, pulse done
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             rd_req,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd;
    logic               is_div_r;
    logic               neg_a;
    logic               neg_b;
    logic               div_zero;

    logic               in_neg_a;
    logic               in_neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign busy  = (state != ST_IDLE);
    assign stall = busy & (start | rd_req | mthi | mtlo);

    // op[0] selects signed; negating the most negative value yields the same
    // bit pattern, which is exactly its unsigned magnitude
    always_comb begin
        in_neg_a = op[0] & srca[WIDTH-1];
        in_neg_b = op[0] & srcb[WIDTH-1];
        mag_a    = in_neg_a ? -srca : srca;
        mag_b    = in_neg_b ? -srcb : srcb;
    end

    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quot = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div  (is_div_r),
        .acc_in  (acc),
        .operand (opnd),
        .acc_out (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div_r <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        state    <= ST_RUN;
                        count    <= CNT_W'(WIDTH - 1);
                        is_div_r <= op[1];
                        neg_a    <= in_neg_a;
                        neg_b    <= in_neg_b;
                        div_zero <= op[1] & (srcb == '0);
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        opnd     <= op[1] ? mag_b : mag_a;
                    end
                end
                ST_RUN: begin
                    acc <= acc_next;
                    if (count == '0) begin
                        state <= ST_FIXUP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ST_FIXUP: begin
                    if (is_div_r) begin
                        // divide by zero: remainder already equals srca after the
                        // magnitude pass and sign restore; only LO needs forcing
                        hi <= rem;
                        lo <= div_zero ? {WIDTH{1'b1}} : quot;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers for the single-cycle MIPS core.
- Replaces the combinational MUL/MFHI/MFLO path in the ALU.
- Runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle. Provides MFHI/MFLO read data and MTHI/MTLO writes.
- Raises stall to freeze the PC and register-file write while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
start  in  1  request a new operation this cycle
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
srca  in  WIDTH  multiplicand or dividend (rs)
srcb  in  WIDTH  multiplier or divisor (rt)
rd_req  in  1  datapath executing MFHI or MFLO this cycle
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  WIDTH  MTHI/MTLO data (rs)
hi  out  WIDTH  current HI register
lo  out  WIDTH  current LO register
busy  out  1  operation in flight
done  out  1  one-cycle pulse after HI/LO receive a result
stall  out  1  datapath must hold the current instruction

Behaviour:
- Reset (reset==0): state=IDLE, hi=0, lo=0, busy=0, done=0, count=0. Reset mid-operation aborts immediately; no partial result is written.
- States:
  - IDLE: start accepted only here.
  - RUN: exactly WIDTH cycles.
  - FIXUP: one cycle, applies signs and writes HI/LO, then returns to IDLE.
- Timing, with accept edge = E0:
  - busy=1 from after E0 through E33; done=1 for the single cycle after E33.
  - Result is visible on hi/lo after E33, so latency is 34 cycles from start to usable data.
- Operand capture at E0:
  - Signed ops store |srca|, |srcb| as unsigned magnitudes, plus flags neg_a, neg_b. Magnitude of 0x80000000 is 0x80000000 (unsigned).
  - Unsigned ops store the operands as-is with both flags 0.
- MUL RUN: shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
- DIV RUN: restoring division, one quotient bit per cycle, MSB first; partial remainder WIDTH+1 bits.
- FIXUP, multiply: product negated (2*WIDTH two's complement) if neg_a^neg_b. HI=product[63:32], LO=product[31:0].
- FIXUP, divide:
  - Quotient is negated if neg_a^neg_b; remainder is negated if neg_a, so the remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - Divide by zero (srcb==0 captured): LO=0xFFFFFFFF, HI=original srca. Latency is unchanged, with no early exit.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude algorithm and needs no exception.
- hi/lo hold their previous values throughout RUN; they change only at FIXUP, MTHI/MTLO, or reset.
- stall = busy & (start | rd_req | mthi | mtlo). This is combinational, so the datapath re-presents the instruction until the unit is idle.
- start while busy is ignored; no queueing.
- mthi/mtlo while busy are ignored (stall is asserted, so the instruction retries).
- mthi/mtlo while IDLE write at the next edge. If start is asserted in the same cycle, both are accepted; the MT write lands at E0 and is overwritten at E33.
- start and a FIXUP cycle never coincide on acceptance, because busy is still 1 during FIXUP.
- Arithmetic is modulo 2^WIDTH per register. The counter wraps to 0 on entering FIXUP.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV;
  - state enum: ST_IDLE, ST_RUN, ST_FIXUP;
  - the WIDTH default.
- One combinational sub-module, muldiv_iter, does a single iteration step: add/shift for multiply, trial-subtract/shift for divide. It is selected by an is_div input.
- The FSM, counter, sign handling and HI/LO registers stay in the top level.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done pulses 34 cycles after start; HI=0xFFFFFFFE, LO=0x00000001; busy high exactly 33 cycles.
- MULT 0xFFFFFFFD*0x00000005 (-3*5) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 100/7 -> LO=14, HI=2. DIV 0xFFFFFFF9/2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x00001234/0 -> LO=0xFFFFFFFF, HI=0x00001234. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- With a MULT in flight:
  - second start plus rd_req at cycle 5 -> stall=1, second op ignored, hi/lo unchanged until done;
  - mtlo 0xAAAA5555 when idle -> lo=0xAAAA5555 next cycle.
- Drive reset=0 at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse; a new start after reset=1 completes normally.
